cga_pixel_serializer: RTL and testbench

Parametrised graphics-mode pixel serializer for the CGA/Tandy display path. It accepts VRAM fetch words through a valid/ready handshake and buffers them in a small FIFO. It shifts them out MSB-first as 1/2/4/8-bit pixel indices, with runtime-selectable depth and horizontal pixel repetition. It sits between the VRAM fetch sequencer and the attribute/palette stage, and generalises the fixed 2-bit/4-bit pixel mux into a buffered, depth-agnostic pipeline with underrun detection.

---
 rtl/cga_pkg.sv | 28 ++
 rtl/cga_sync_fifo.sv | 57 +++++
 rtl/cga_pixel_serializer.sv | 204 ++++++++++++++++++++
 tb/tb_cga_pixel_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cga_pkg.sv
// Shared types for the CGA/Tandy pixel serializer: pixel depth, FSM states
// and the depth-to-bit-count helper.
package cga_pkg;

    typedef enum logic [1:0] {
        BPP1 = 2'd0,
        BPP2 = 2'd1,
        BPP4 = 2'd2,
        BPP8 = 2'd3
    } bpp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        ACTIVE  = 2'd2,
        STARVED = 2'd3
    } state_t;

    function automatic logic [3:0] bpp_bits(input bpp_t bpp);
        case (bpp)
            BPP1:    bpp_bits = 4'd1;
            BPP2:    bpp_bits = 4'd2;
            BPP4:    bpp_bits = 4'd4;
            default: bpp_bits = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/cga_sync_fifo.sv
// Small first-word-fall-through FIFO buffering VRAM fetch words ahead of the
// pixel shifter. Occupancy is kept in a registered counter.
module cga_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;
    // Read port falls through so the head word is usable in the pop cycle.
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cga_pixel_serializer.sv
// Buffered graphics-mode pixel serializer: fetch words in, MSB-first 1/2/4/8-bit
// pixel indices out, with per-line depth/repeat selection and underrun flag.
module cga_pixel_serializer
    import cga_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_REP    = 4,
    parameter int REP_W      = (MAX_REP > 1) ? $clog2(MAX_REP) : 1,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        bpp_sel,
    input  logic [REP_W-1:0]  rep_sel,
    input  logic              line_start,
    input  logic              pix_ena,
    input  logic              display_enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [7:0]        pix_out,
    output logic              pix_valid,
    output logic              underflow,
    output logic [CNT_W-1:0]  fill_level
);
    localparam int BL_W = $clog2(DATA_W + 1);

    state_t            state_reg, state_next;
    bpp_t              bpp_reg, bpp_next;
    logic [REP_W-1:0]  rep_reg, rep_next;
    logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [BL_W-1:0]   bits_left_reg, bits_left_next;
    logic [7:0]        pix_out_reg, pix_out_next;
    logic              pix_valid_reg, pix_valid_next;
    logic              underflow_reg, underflow_next;
    logic              ready_en_reg;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              load_word;
    logic              demand;
    logic [BL_W-1:0]   bpp_w;
    logic [7:0]        pix_top;

    // Ready is held off until the first edge after reset is released.
    assign in_ready  = ready_en_reg && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign demand    = pix_ena && display_enable;
    assign bpp_w     = BL_W'(bpp_bits(bpp_reg));

    cga_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fill_level)
    );

    always_comb begin
        case (bpp_reg)
            BPP1:    pix_top = {7'd0, shift_reg[DATA_W-1]};
            BPP2:    pix_top = {6'd0, shift_reg[DATA_W-1 -: 2]};
            BPP4:    pix_top = {4'd0, shift_reg[DATA_W-1 -: 4]};
            default: pix_top = shift_reg[DATA_W-1 -: 8];
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        bpp_next       = bpp_reg;
        rep_next       = rep_reg;
        rep_cnt_next   = rep_cnt_reg;
        shift_next     = shift_reg;
        bits_left_next = bits_left_reg;
        pix_out_next   = pix_out_reg;
        pix_valid_next = pix_valid_reg;
        underflow_next = underflow_reg;
        fifo_pop       = 1'b0;
        load_word      = 1'b0;

        if (line_start) begin
            // FIFO is deliberately untouched: fetch runs ahead of display.
            bpp_next       = bpp_t'(bpp_sel);
            rep_next       = rep_sel;
            underflow_next = 1'b0;
            shift_next     = '0;
            bits_left_next = '0;
            rep_cnt_next   = '0;
            state_next     = LOAD;
            if (pix_ena) begin
                pix_out_next   = 8'd0;
                pix_valid_next = 1'b0;
            end
        end else begin
            if (pix_ena && !display_enable) begin
                pix_out_next   = 8'd0;
                pix_valid_next = 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    pix_out_next = 8'd0;
                    if (pix_ena) pix_valid_next = 1'b0;
                end
                LOAD: begin
                    if (!fifo_empty) begin
                        load_word = 1'b1;
                        if (demand) begin
                            pix_out_next   = 8'd0;
                            pix_valid_next = 1'b0;
                        end
                    end else if (demand) begin
                        pix_out_next   = 8'd0;
                        pix_valid_next = 1'b1;
                        underflow_next = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (demand) begin
                        pix_out_next   = pix_top;
                        pix_valid_next = 1'b1;
                        if (rep_cnt_reg == rep_reg) begin
                            rep_cnt_next = '0;
                            if (bits_left_reg == bpp_w) begin
                                if (!fifo_empty) begin
                                    load_word = 1'b1;
                                end else begin
                                    shift_next     = '0;
                                    bits_left_next = '0;
                                    state_next     = STARVED;
                                end
                            end else begin
                                shift_next     = shift_reg << bpp_bits(bpp_reg);
                                bits_left_next = bits_left_reg - bpp_w;
                            end
                        end else begin
                            rep_cnt_next = rep_cnt_reg + REP_W'(1);
                        end
                    end
                end
                STARVED: begin
                    if (demand) begin
                        pix_out_next   = 8'd0;
                        pix_valid_next = 1'b1;
                        underflow_next = 1'b1;
                    end
                    if (!fifo_empty) load_word = 1'b1;
                end
                default: state_next = IDLE;
            endcase

            if (load_word) begin
                fifo_pop       = 1'b1;
                shift_next     = fifo_data;
                bits_left_next = BL_W'(DATA_W);
                rep_cnt_next   = '0;
                state_next     = ACTIVE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            bpp_reg       <= BPP1;
            rep_reg       <= '0;
            rep_cnt_reg   <= '0;
            shift_reg     <= '0;
            bits_left_reg <= '0;
            pix_out_reg   <= 8'd0;
            pix_valid_reg <= 1'b0;
            underflow_reg <= 1'b0;
            ready_en_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bpp_reg       <= bpp_next;
            rep_reg       <= rep_next;
            rep_cnt_reg   <= rep_cnt_next;
            shift_reg     <= shift_next;
            bits_left_reg <= bits_left_next;
            pix_out_reg   <= pix_out_next;
            pix_valid_reg <= pix_valid_next;
            underflow_reg <= underflow_next;
            ready_en_reg  <= 1'b1;
        end
    end

    assign pix_out   = pix_out_reg;
    assign pix_valid = pix_valid_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_cga_pixel_serializer.sv
// Directed bench for cga_pixel_serializer: an 8-bit-word and a 16-bit-word
// instance share the line/pixel timing inputs but have separate fetch ports.
module tb_cga_pixel_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  bpp_sel;
    logic [1:0]  rep_sel;
    logic        line_start;
    logic        pix_ena;
    logic        display_enable;

    logic        in_valid8;
    logic [7:0]  in_data8;
    logic        in_ready8;
    logic [7:0]  pix_out8;
    logic        pix_valid8;
    logic        underflow8;
    logic [2:0]  fill_level8;

    logic        in_valid16;
    logic [15:0] in_data16;
    logic        in_ready16;
    logic [7:0]  pix_out16;
    logic        pix_valid16;
    logic        underflow16;
    logic [2:0]  fill_level16;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cga_pixel_serializer #(.DATA_W(8), .FIFO_DEPTH(4), .MAX_REP(4)) u_dut8 (
        .clk            (clk),
        .reset_n        (reset_n),
        .bpp_sel        (bpp_sel),
        .rep_sel        (rep_sel),
        .line_start     (line_start),
        .pix_ena        (pix_ena),
        .display_enable (display_enable),
        .in_valid       (in_valid8),
        .in_data        (in_data8),
        .in_ready       (in_ready8),
        .pix_out        (pix_out8),
        .pix_valid      (pix_valid8),
        .underflow      (underflow8),
        .fill_level     (fill_level8)
    );

    cga_pixel_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .MAX_REP(4)) u_dut16 (
        .clk            (clk),
        .reset_n        (reset_n),
        .bpp_sel        (bpp_sel),
        .rep_sel        (rep_sel),
        .line_start     (line_start),
        .pix_ena        (pix_ena),
        .display_enable (display_enable),
        .in_valid       (in_valid16),
        .in_data        (in_data16),
        .in_ready       (in_ready16),
        .pix_out        (pix_out16),
        .pix_valid      (pix_valid16),
        .underflow      (underflow16),
        .fill_level     (fill_level16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // line_start, then push one word into the 8-bit instance while it sits in
    // LOAD, then let LOAD pop it; the next pixel tick yields the first pixel.
    task automatic start_line8(input logic [7:0] word);
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        in_valid8  = 1'b1;
        in_data8   = word;
        step();
        in_valid8  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        vectors++; if (pix_out8 !== 8'h00) begin miscompares++; $display("FAIL reset_pix_out: got %0h want 0", pix_out8); end
        vectors++; if (pix_valid8 !== 1'b0) begin miscompares++; $display("FAIL reset_pix_valid: got %0b want 0", pix_valid8); end
        vectors++; if (underflow8 !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %0b want 0", underflow8); end
        vectors++; if (fill_level8 !== 3'd0) begin miscompares++; $display("FAIL reset_fill: got %0d want 0", fill_level8); end
        vectors++; if (in_ready8 !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_low: got %0b want 0", in_ready8); end
        reset_n = 1'b1;
        step();
        vectors++; if (in_ready8 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_release: got %0b want 1", in_ready8); end
        $display("reset: in_ready=%0b fill=%0d", in_ready8, fill_level8);
    endtask

    task automatic test_4bpp_words();
        logic [7:0] exp [8] = '{8'h1, 8'h2, 8'hA, 8'hB, 8'hC, 8'hD, 8'hE, 8'hF};
        bpp_sel = 2'd2;
        rep_sel = 2'd0;
        in_valid16 = 1'b1;
        in_data16  = 16'h12AB;
        step();
        in_data16  = 16'hCDEF;
        step();
        in_valid16 = 1'b0;
        vectors++; if (fill_level16 !== 3'd2) begin miscompares++; $display("FAIL bpp4_fill: got %0d want 2", fill_level16); end
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        step();
        pix_ena = 1'b1;
        display_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++; if (pix_out16 !== exp[i] || pix_valid16 !== 1'b1) begin miscompares++; $display("FAIL bpp4_pix%0d: got %0h/%0b want %0h/1", i, pix_out16, pix_valid16, exp[i]); end
        end
        pix_ena = 1'b0;
        $display("bpp4: two words serialized, fill=%0d", fill_level16);
    endtask

    task automatic test_1bpp();
        logic [7:0] exp [8] = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1};
        bpp_sel = 2'd0;
        rep_sel = 2'd0;
        start_line8(8'hA5);
        pix_ena = 1'b1;
        display_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++; if (pix_out8 !== exp[i] || pix_valid8 !== 1'b1 || underflow8 !== 1'b0) begin miscompares++; $display("FAIL bpp1_pix%0d: got %0h/%0b/%0b want %0h/1/0", i, pix_out8, pix_valid8, underflow8, exp[i]); end
        end
        pix_ena = 1'b0;
        $display("bpp1: word A5 serialized");
    endtask

    task automatic test_2bpp_repeat();
        logic [7:0] exp [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
        bpp_sel = 2'd1;
        rep_sel = 2'd1;
        start_line8(8'h1B);
        bpp_sel = 2'd3;
        rep_sel = 2'd0;
        pix_ena = 1'b1;
        display_enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++; if (pix_out8 !== exp[i] || pix_valid8 !== 1'b1) begin miscompares++; $display("FAIL bpp2_rep_pix%0d: got %0h/%0b want %0h/1", i, pix_out8, pix_valid8, exp[i]); end
        end
        pix_ena = 1'b0;
        $display("bpp2 rep2: word 1B serialized");
    endtask

    task automatic test_underflow();
        bpp_sel = 2'd3;
        rep_sel = 2'd0;
        start_line8(8'h3C);
        pix_ena = 1'b1;
        display_enable = 1'b1;
        step();
        vectors++; if (pix_out8 !== 8'h3C || pix_valid8 !== 1'b1 || underflow8 !== 1'b0) begin miscompares++; $display("FAIL uf_first: got %0h/%0b/%0b want 3c/1/0", pix_out8, pix_valid8, underflow8); end
        step();
        vectors++; if (pix_out8 !== 8'h00 || pix_valid8 !== 1'b1 || underflow8 !== 1'b1) begin miscompares++; $display("FAIL uf_second: got %0h/%0b/%0b want 0/1/1", pix_out8, pix_valid8, underflow8); end
        pix_ena = 1'b0;
        step();
        vectors++; if (underflow8 !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %0b want 1", underflow8); end
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        vectors++; if (underflow8 !== 1'b0) begin miscompares++; $display("FAIL uf_clear: got %0b want 0", underflow8); end
        pix_ena = 1'b1;
        display_enable = 1'b0;
        step();
        vectors++; if (pix_out8 !== 8'h00 || pix_valid8 !== 1'b0 || underflow8 !== 1'b0) begin miscompares++; $display("FAIL blank_tick: got %0h/%0b/%0b want 0/0/0", pix_out8, pix_valid8, underflow8); end
        pix_ena = 1'b0;
        $display("underflow: set by starved pixel, cleared by line_start");
    endtask

    task automatic test_fifo_full();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        bpp_sel = 2'd3;
        rep_sel = 2'd0;
        in_valid8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data8 = 8'h10 + 8'(k);
            step();
        end
        in_data8 = 8'h14;
        step();
        vectors++; if (in_ready8 !== 1'b0 || fill_level8 !== 3'd4) begin miscompares++; $display("FAIL full_hold: got ready=%0b fill=%0d want 0/4", in_ready8, fill_level8); end
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        step();
        vectors++; if (in_ready8 !== 1'b1 || fill_level8 !== 3'd3) begin miscompares++; $display("FAIL pop_from_full: got ready=%0b fill=%0d want 1/3", in_ready8, fill_level8); end
        pix_ena = 1'b1;
        display_enable = 1'b1;
        step();
        vectors++; if (pix_out8 !== 8'h10 || fill_level8 !== 3'd3) begin miscompares++; $display("FAIL push_pop: got pix=%0h fill=%0d want 10/3", pix_out8, fill_level8); end
        in_valid8 = 1'b0;
        step();
        vectors++; if (pix_out8 !== 8'h11 || fill_level8 !== 3'd2) begin miscompares++; $display("FAIL reload_order: got pix=%0h fill=%0d want 11/2", pix_out8, fill_level8); end
        pix_ena = 1'b0;
        $display("fifo_full: fill=%0d after push/pop traffic", fill_level8);
    endtask

    task automatic test_reset_mid_line();
        in_valid8 = 1'b1;
        in_data8  = 8'h20;
        step();
        in_data8  = 8'h21;
        step();
        in_valid8 = 1'b0;
        pix_ena = 1'b1;
        display_enable = 1'b1;
        step();
        vectors++; if (pix_out8 !== 8'h12 || pix_valid8 !== 1'b1) begin miscompares++; $display("FAIL mid_pix: got %0h/%0b want 12/1", pix_out8, pix_valid8); end
        pix_ena = 1'b0;
        in_valid8 = 1'b1;
        in_data8  = 8'h22;
        step();
        in_valid8 = 1'b0;
        vectors++; if (fill_level8 !== 3'd4) begin miscompares++; $display("FAIL mid_full: got %0d want 4", fill_level8); end
        reset_n = 1'b0;
        pix_ena = 1'b1;
        step();
        vectors++; if (pix_out8 !== 8'h00 || pix_valid8 !== 1'b0 || fill_level8 !== 3'd0 || in_ready8 !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got pix=%0h valid=%0b fill=%0d ready=%0b want 0/0/0/0", pix_out8, pix_valid8, fill_level8, in_ready8); end
        reset_n = 1'b1;
        pix_ena = 1'b0;
        step();
        vectors++; if (in_ready8 !== 1'b1) begin miscompares++; $display("FAIL mid_release_ready: got %0b want 1", in_ready8); end
        pix_ena = 1'b1;
        step();
        vectors++; if (pix_valid8 !== 1'b0 || pix_out8 !== 8'h00) begin miscompares++; $display("FAIL idle_tick: got %0h/%0b want 0/0", pix_out8, pix_valid8); end
        pix_ena = 1'b0;
        $display("reset_mid_line: FIFO flushed, idle after release");
    endtask

    initial begin
        reset_n        = 1'b0;
        bpp_sel        = 2'd0;
        rep_sel        = 2'd0;
        line_start     = 1'b0;
        pix_ena        = 1'b0;
        display_enable = 1'b0;
        in_valid8      = 1'b0;
        in_data8       = 8'h00;
        in_valid16     = 1'b0;
        in_data16      = 16'h0000;
        #1;
        test_reset();
        test_4bpp_words();
        test_1bpp();
        test_2bpp_repeat();
        test_underflow();
        test_fifo_full();
        test_reset_mid_line();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
